dcache_direct_mapped: RTL

Direct-mapped, write-back, write-allocate data cache that sits between the pipeline's D-cache port and the external memory. It is the responder for the core's word-addressed `ren`/`wen`/`addr`/`rdata`/`wdata`/`stall` interface. On a miss it initiates 128-bit block transfers to memory over a `read`/`write`/`ready` handshake. Hits complete in the request cycle with no stall.

---
 rtl/dcache_direct_mapped_if.sv | 31 +++
 rtl/dcache_direct_mapped.sv | 125 ++++++++++++
 2 files changed

// File: rtl/dcache_direct_mapped_if.sv
// Purpose: bundles the core-side load/store port and the memory-side block port of the data cache.
// Latency: wires only, no storage.
// Backpressure: the core waits on proc_stall; memory completes each block transfer with a mem_ready pulse.
interface dcache_direct_mapped_if;
    // Core side: word-addressed load/store requests.
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    // Memory side: 128-bit block transfers.
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    // The cache: responder to the core, requester to memory.
    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    // The environment around the cache: the core plus the memory.
    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_direct_mapped.sv
// Purpose: direct-mapped, write-back, write-allocate data cache between the core and block memory.
// Latency: hits complete in the request cycle; a clean miss costs k+1 stall cycles, where k is the fill wait; a dirty miss adds the write-back wait.
// Backpressure: proc_stall holds the core; each mem_read/mem_write level is held until its mem_ready pulse.
module dcache_direct_mapped #(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_W      = $clog2(NUM_BLOCKS),
    parameter int TAG_W      = 28 - IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    dcache_direct_mapped_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_mem_read;
    logic                    r_mem_write;
    logic [NUM_BLOCKS-1:0]   r_valid;
    logic [NUM_BLOCKS-1:0]   r_dirty;
    logic [TAG_W-1:0]        r_tag  [NUM_BLOCKS];
    logic [127:0]            r_data [NUM_BLOCKS];

    logic [1:0]              w_word;
    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_req;
    logic                    w_is_write;
    logic                    w_hit;
    logic                    w_victim_dirty;
    logic [127:0]            w_line;
    logic [127:0]            w_merged;

    // The request is not latched: the core holds proc_* stable while stalled.
    assign w_word         = bus.proc_addr[1:0];
    assign w_idx          = bus.proc_addr[IDX_W+1:2];
    assign w_tag          = bus.proc_addr[29:IDX_W+2];
    assign w_req          = bus.proc_read | bus.proc_write;
    assign w_is_write     = bus.proc_write;
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_line         = r_data[w_idx];

    // Store data spliced into the selected word of the indexed line.
    always_comb begin
        w_merged = w_line;
        w_merged[{w_word, 5'b0} +: 32] = bus.proc_wdata;
    end

    assign bus.proc_rdata = w_line[{w_word, 5'b0} +: 32];
    assign bus.proc_stall = (r_state == S_IDLE) ? (w_req && !w_hit) : 1'b1;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_wdata  = w_line;
    // Write-back targets the victim's block; a fill targets the requested block.
    assign bus.mem_addr   = (r_state == S_WRITEBACK) ? {r_tag[w_idx], w_idx}
                                                     : bus.proc_addr[29:2];

    // Control FSM with registered memory requests plus the valid/dirty bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_valid     <= '0;
            r_dirty     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (w_is_write) begin
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else if (w_victim_dirty) begin
                            r_state     <= S_WRITEBACK;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state    <= S_ALLOCATE;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ready) begin
                        r_state     <= S_ALLOCATE;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                    end
                end
                S_ALLOCATE: begin
                    if (bus.mem_ready) begin
                        r_state        <= S_IDLE;
                        r_mem_read     <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays are never reset; valid bits gate their contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_IDLE && w_req && w_hit && w_is_write) begin
                r_data[w_idx] <= w_merged;
            end
            if (r_state == S_ALLOCATE && bus.mem_ready) begin
                r_data[w_idx] <= bus.mem_rdata;
                r_tag[w_idx]  <= w_tag;
            end
        end
    end

endmodule
